// File: rtl/instr_prefetch_pkg.sv
// Shared core constants and the fetch-queue entry layout.
package instr_prefetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_sync_fifo.sv
// Power-of-two synchronous FIFO with flush and occupancy count.
module sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: issues ITCM reads ahead of decode into a small
// queue, kills in-flight responses on redirect.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] itcm_addr,
    output logic            itcm_req,
    input  logic [XLEN-1:0] itcm_datain,
    input  logic            pc_jump,
    input  logic [XLEN-1:0] pc_jump_addr,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;
    localparam logic [XLEN-1:0] ALIGN = 32'hFFFF_FFFC;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic            valid;
    logic [OW-1:0]   occupancy;
    fetch_entry_t    entry;
    fetch_entry_t    head;
    logic [2*XLEN-1:0] head_bits;

    // A redirect hides the head immediately so no stale instruction leaks.
    assign valid = (count != '0) && !pc_jump;
    assign pop   = valid && ready_i;
    assign push  = inflight && !pc_jump;

    // Slots promised = queued + in flight; a pop this cycle frees one.
    assign occupancy = OW'(count) + OW'(inflight);
    assign itcm_req  = !rst && !pc_jump
                     && (occupancy < OW'(DEPTH) + OW'(pop));
    assign itcm_addr = fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC & ALIGN;
            req_pc   <= RESET_PC & ALIGN;
            inflight <= 1'b0;
        end else begin
            inflight <= itcm_req;
            if (pc_jump) begin
                fetch_pc <= pc_jump_addr & ALIGN;
            end else if (itcm_req) begin
                fetch_pc <= fetch_pc + PC_INC;
                req_pc   <= fetch_pc;
            end
        end
    end

    assign entry = '{pc: req_pc, instr: itcm_datain};

    sync_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(2 * XLEN)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(pc_jump),
        .din  (entry),
        .dout (head_bits),
        .count(count)
    );

    assign head    = head_bits;
    assign valid_o = valid;
    assign instr_o = valid ? head.instr : NOP;
    assign pc_o    = valid ? head.pc : '0;

endmodule
